// File: rtl/matrix_line_ctrl_if.sv
// Bundle of the pixel stream in, the two line-RAM ports and the 3-row window out.
// The master view belongs to the controller; the slave view belongs to the stream source, the RAMs and the sink.
interface matrix_line_ctrl_if #(
  parameter int DATA_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH = 9
);
  logic                     s_sof;
  logic                     s_eol;
  logic                     s_valid;
  logic [DATA_BITWIDTH-1:0] s_data;
  logic [1:0]               ram_wea;
  logic [ADDR_BITWIDTH-1:0] ram_addra;
  logic [DATA_BITWIDTH-1:0] ram_dina;
  logic                     ram_enb;
  logic [ADDR_BITWIDTH-1:0] ram_addrb;
  logic [DATA_BITWIDTH-1:0] ram_doutb0;
  logic [DATA_BITWIDTH-1:0] ram_doutb1;
  logic                     m_valid;
  logic [DATA_BITWIDTH-1:0] m_row0;
  logic [DATA_BITWIDTH-1:0] m_row1;
  logic [DATA_BITWIDTH-1:0] m_row2;
  logic                     m_sol;
  logic                     m_eol;
  logic                     line_err;

  modport master (
    input  s_sof, s_eol, s_valid, s_data, ram_doutb0, ram_doutb1,
    output ram_wea, ram_addra, ram_dina, ram_enb, ram_addrb,
    output m_valid, m_row0, m_row1, m_row2, m_sol, m_eol, line_err
  );

  modport slave (
    output s_sof, s_eol, s_valid, s_data, ram_doutb0, ram_doutb1,
    input  ram_wea, ram_addra, ram_dina, ram_enb, ram_addrb,
    input  m_valid, m_row0, m_row1, m_row2, m_sol, m_eol, line_err
  );
endinterface

// File: rtl/matrix_line_ctrl.sv
// Line-buffer sequencer for the 3x3 window generator: rotates two read-before-write
// line RAMs and returns current / previous / line-before rows for every pixel.
module matrix_line_ctrl #(
  parameter int IMG_WIDTH     = 300,
  parameter int ADDR_BITWIDTH = $clog2(IMG_WIDTH + 1),
  parameter int DATA_BITWIDTH = 8,
  parameter int RAM_DELAY     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  matrix_line_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, FILL0, FILL1, RUN} state_t;

  localparam logic [ADDR_BITWIDTH-1:0] COL_LAST = ADDR_BITWIDTH'(IMG_WIDTH - 1);
  localparam int                       L        = RAM_DELAY - 1;

  state_t                   state_q, state_d;
  logic [ADDR_BITWIDTH-1:0] col_q, col_d;
  logic                     wr_sel_q, wr_sel_d;
  logic                     err_q, err_d;

  logic                     sof_hit, accept, col_last, line_end, sel_eff;
  state_t                   st_eff;
  logic [ADDR_BITWIDTH-1:0] col_eff;

  logic                     dly_vld_q  [RAM_DELAY];
  logic [DATA_BITWIDTH-1:0] dly_data_q [RAM_DELAY];
  logic                     dly_sol_q  [RAM_DELAY];
  logic                     dly_eol_q  [RAM_DELAY];
  logic                     dly_sel_q  [RAM_DELAY];
  state_t                   dly_st_q   [RAM_DELAY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      col_q    <= '0;
      wr_sel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      wr_sel_q <= wr_sel_d;
      err_q    <= err_d;
    end
  end

  // A frame start overrides the registered position so that pixel lands as column 0 of FILL0.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    wr_sel_d = wr_sel_q;
    err_d    = err_q;

    sof_hit  = bus.s_valid & bus.s_sof;
    accept   = bus.s_valid & (bus.s_sof | (state_q != IDLE));
    st_eff   = sof_hit ? FILL0 : state_q;
    col_eff  = sof_hit ? '0 : col_q;
    sel_eff  = sof_hit ? 1'b0 : wr_sel_q;
    col_last = (col_eff == COL_LAST);
    line_end = bus.s_eol | col_last;

    if (accept) begin
      if (line_end) begin
        col_d    = '0;
        wr_sel_d = ~sel_eff;
        state_d  = (st_eff == FILL0) ? FILL1 : RUN;
      end else begin
        col_d    = col_eff + ADDR_BITWIDTH'(1);
        wr_sel_d = sel_eff;
        state_d  = st_eff;
      end
      if (bus.s_eol ^ col_last) err_d = 1'b1;
    end

    bus.ram_wea   = accept ? (sel_eff ? 2'b10 : 2'b01) : 2'b00;
    bus.ram_addra = col_eff;
    bus.ram_addrb = col_eff;
    bus.ram_dina  = bus.s_data;
    bus.ram_enb   = accept;
  end

  // Pixel side-band delayed to line up with the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_DELAY; i++) begin
        dly_vld_q[i]  <= 1'b0;
        dly_data_q[i] <= '0;
        dly_sol_q[i]  <= 1'b0;
        dly_eol_q[i]  <= 1'b0;
        dly_sel_q[i]  <= 1'b0;
        dly_st_q[i]   <= IDLE;
      end
    end else begin
      dly_vld_q[0]  <= accept;
      dly_data_q[0] <= accept ? bus.s_data : '0;
      dly_sol_q[0]  <= accept & (col_eff == '0);
      dly_eol_q[0]  <= accept & line_end;
      dly_sel_q[0]  <= sel_eff;
      dly_st_q[0]   <= st_eff;
      for (int i = 1; i < RAM_DELAY; i++) begin
        dly_vld_q[i]  <= dly_vld_q[i-1];
        dly_data_q[i] <= dly_data_q[i-1];
        dly_sol_q[i]  <= dly_sol_q[i-1];
        dly_eol_q[i]  <= dly_eol_q[i-1];
        dly_sel_q[i]  <= dly_sel_q[i-1];
        dly_st_q[i]   <= dly_st_q[i-1];
      end
    end
  end

  // Row 1/2 come straight off the RAM read ports; the selects and masks are registered.
  assign bus.m_valid  = dly_vld_q[L];
  assign bus.m_row0   = dly_data_q[L];
  assign bus.m_row1   = (dly_vld_q[L] && dly_st_q[L] != FILL0) ?
                        (dly_sel_q[L] ? bus.ram_doutb0 : bus.ram_doutb1) : '0;
  assign bus.m_row2   = (dly_vld_q[L] && dly_st_q[L] == RUN) ?
                        (dly_sel_q[L] ? bus.ram_doutb1 : bus.ram_doutb0) : '0;
  assign bus.m_sol    = dly_sol_q[L];
  assign bus.m_eol    = dly_eol_q[L];
  assign bus.line_err = err_q;
endmodule
